// File: rtl/mult_div_pkg.sv
// mult_div_pkg: shared state encoding, op codes and iteration count for mult_div_seq.
package mult_div_pkg;

    typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_e;

    localparam logic OP_MULT    = 1'b0;
    localparam logic OP_DIV     = 1'b1;
    localparam int   ITERATIONS = 32;

    function automatic logic [31:0] abs32(input logic [31:0] x);
        return x[31] ? -x : x;
    endfunction

endpackage

// File: rtl/mult_div_seq.sv
// mult_div_seq: sequential signed 32x32 multiply (radix-2 Booth) and divide (restoring),
// 32 iterations each, 64-bit hi/lo result held until the next successful operation.
module mult_div_seq
    import mult_div_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        op,
    input  logic [31:0] a_in,
    input  logic [31:0] b_in,
    output logic        busy,
    output logic        done,
    output logic        div_zero,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out
);

    state_e      state_q;
    logic [4:0]  cnt_q;
    logic [32:0] u_q;
    logic [31:0] l_q;
    logic [31:0] m_q;
    logic        q_m1_q;
    logic        neg_q_q;
    logic        neg_r_q;
    logic        busy_q;
    logic        done_q;
    logic        dz_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;

    // u_q is the Booth upper partial product or the divide remainder; l_q is the
    // multiplier being shifted out or the dividend shifting into the quotient.
    logic [32:0] m_ext;
    logic [32:0] booth_sum;
    logic [32:0] shifted;
    logic [32:0] trial;
    logic        ge;
    logic [32:0] u_d;
    logic [31:0] l_d;
    logic [31:0] res_hi;
    logic [31:0] res_lo;

    always_comb begin
        m_ext     = {m_q[31], m_q};
        booth_sum = ({l_q[0], q_m1_q} == 2'b01) ? u_q + m_ext :
                    ({l_q[0], q_m1_q} == 2'b10) ? u_q - m_ext : u_q;
        shifted   = {u_q[31:0], l_q[31]};
        trial     = shifted - {1'b0, m_q};
        ge        = !trial[32];
        u_d       = (state_q == DIV) ? (ge ? trial : shifted) : {booth_sum[32], booth_sum[32:1]};
        l_d       = (state_q == DIV) ? {l_q[30:0], ge} : {booth_sum[0], l_q[31:1]};
        res_hi    = (state_q == DIV) ? (neg_r_q ? -u_d[31:0] : u_d[31:0]) : u_d[31:0];
        res_lo    = (state_q == DIV) ? (neg_q_q ? -l_d : l_d) : l_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            u_q     <= '0;
            l_q     <= '0;
            m_q     <= '0;
            q_m1_q  <= 1'b0;
            neg_q_q <= 1'b0;
            neg_r_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_q  <= '0;
                    done_q <= 1'b0;
                    dz_q   <= 1'b0;
                    if (start) begin
                        if (op == OP_DIV && b_in == '0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            dz_q    <= 1'b1;
                        end else if (op == OP_DIV) begin
                            state_q <= DIV;
                            busy_q  <= 1'b1;
                            u_q     <= '0;
                            l_q     <= abs32(a_in);
                            m_q     <= abs32(b_in);
                            neg_q_q <= a_in[31] ^ b_in[31];
                            neg_r_q <= a_in[31];
                        end else begin
                            state_q <= MULT;
                            busy_q  <= 1'b1;
                            u_q     <= '0;
                            l_q     <= b_in;
                            m_q     <= a_in;
                            q_m1_q  <= 1'b0;
                        end
                    end
                end
                MULT, DIV: begin
                    u_q    <= u_d;
                    l_q    <= l_d;
                    q_m1_q <= l_q[0];
                    cnt_q  <= cnt_q + 5'd1;
                    if (cnt_q == 5'(ITERATIONS - 1)) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        hi_q    <= res_hi;
                        lo_q    <= res_lo;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    dz_q    <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign div_zero = dz_q;
    assign hi_out   = hi_q;
    assign lo_out   = lo_q;

endmodule

// File: tb/tb_mult_div_seq.sv
// tb_mult_div_seq: directed vectors against a cycle-count/arithmetic reference model
// plus literal expectations for the key results.
module tb_mult_div_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        op = 1'b0;
    logic [31:0] a_in = '0;
    logic [31:0] b_in = '0;
    logic        busy, done, div_zero;
    logic [31:0] hi_out, lo_out;

    int n_cmp = 0;
    int n_err = 0;
    logic chk_en = 1'b0;

    mult_div_seq dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a_in(a_in), .b_in(b_in),
        .busy(busy), .done(done), .div_zero(div_zero), .hi_out(hi_out), .lo_out(lo_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: results from plain 64-bit arithmetic, timing from a cycles-left count.
    logic        m_busy = 0, m_done = 0, m_dz = 0;
    logic [31:0] m_hi = 0, m_lo = 0, p_hi = 0, p_lo = 0;
    int          m_left = 0;

    always @(posedge clk) begin
        longint sa, sb, p, q, r;
        if (reset) begin
            m_busy = 0; m_done = 0; m_dz = 0; m_hi = 0; m_lo = 0; m_left = 0;
        end else if (m_done) begin
            m_done = 0; m_dz = 0;
        end else if (m_busy) begin
            m_left--;
            if (m_left == 0) begin
                m_busy = 0; m_done = 1; m_hi = p_hi; m_lo = p_lo;
            end
        end else if (start) begin
            sa = longint'($signed(a_in));
            sb = longint'($signed(b_in));
            if (op && b_in == 0) begin
                m_done = 1; m_dz = 1;
            end else begin
                if (op) begin
                    q = sa / sb;
                    r = sa % sb;
                    p_hi = r[31:0]; p_lo = q[31:0];
                end else begin
                    p = sa * sb;
                    p_hi = p[63:32]; p_lo = p[31:0];
                end
                m_busy = 1; m_left = 32;
            end
        end
    end

    always @(negedge clk)
        if (chk_en)
            chk("model", {29'd0, busy, done, div_zero, hi_out, lo_out},
                {29'd0, m_busy, m_done, m_dz, m_hi, m_lo});

    // Launch one op, scramble inputs afterwards, and return the cycle done was seen.
    task automatic run(input logic o, input logic [31:0] a, input logic [31:0] b,
                       input int exp_cyc, input logic [31:0] eh, input logic [31:0] el,
                       input logic edz, input string name);
        int n;
        @(negedge clk);
        start = 1'b1; op = o; a_in = a; b_in = b;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            start = 1'b0; op = 1'($urandom); a_in = $urandom; b_in = $urandom;
        end while (!done && n < 40);
        chk({name, "_cycle"}, 64'(n), 64'(exp_cyc));
        chk({name, "_hi"}, 64'(hi_out), 64'(eh));
        chk({name, "_lo"}, 64'(lo_out), 64'(el));
        chk({name, "_dz"}, 64'(div_zero), 64'(edz));
    endtask

    initial begin
        int seen_done;
        repeat (3) @(negedge clk);
        chk("reset_state", {29'd0, busy, done, div_zero, hi_out, lo_out}, 64'd0);
        reset = 1'b0;
        chk_en = 1'b1;

        run(0, 32'd7, 32'hFFFFFFFD, 33, 32'hFFFFFFFF, 32'hFFFFFFEB, 0, "mul_7xm3");
        run(0, 32'h7FFFFFFF, 32'h7FFFFFFF, 33, 32'h3FFFFFFF, 32'h00000001, 0, "mul_max");
        run(0, 32'h80000000, 32'h80000000, 33, 32'h40000000, 32'h00000000, 0, "mul_min");
        run(0, 32'h12345678, 32'd0, 33, 32'h0, 32'h0, 0, "mul_zero");
        run(1, 32'hFFFFFFF9, 32'd2, 33, 32'hFFFFFFFF, 32'hFFFFFFFD, 0, "div_m7_2");
        run(1, 32'd7, 32'hFFFFFFFE, 33, 32'h00000001, 32'hFFFFFFFD, 0, "div_7_m2");
        run(1, 32'h451, 32'h20, 33, 32'h11, 32'h22, 0, "div_prior");
        run(1, 32'd5, 32'd0, 1, 32'h11, 32'h22, 1, "div_zero");
        run(1, 32'h80000000, 32'hFFFFFFFF, 33, 32'h0, 32'h80000000, 0, "div_wrap");
        run(1, 32'd1000, 32'd7, 33, 32'd6, 32'd142, 0, "div_1000_7");

        // Restart attempt mid-op is ignored; reset mid-op aborts with no done.
        @(negedge clk);
        start = 1'b1; op = 1'b0; a_in = 32'd3; b_in = 32'd5;
        seen_done = 0;
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            if (done) seen_done++;
            start = (c == 5); op = 1'b1; a_in = 32'd9; b_in = 32'd0;
            reset = (c == 10);
            if (c == 6) chk("restart_busy", 64'(busy), 64'd1);
        end
        chk("abort_no_done", 64'(seen_done), 64'd0);
        chk("abort_outputs", {29'd0, busy, done, div_zero, hi_out, lo_out}, 64'd0);
        reset = 1'b0;
        run(0, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 32'h0, 32'h1, 0, "mul_after_abort");

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mult_div_seq.md
MULT_DIV_SEQ -- requirements
Module: mult_div_seq

Interface
REQ-001 The block SHALL have a single clock and a synchronous, active-high reset; the ports are named clk and reset.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  one-cycle request from the control unit; sampled only in IDLE.
REQ-005 op  input  1  0 = signed multiply, 1 = signed divide; sampled with start.
REQ-006 a_in  input  32  multiplicand / dividend (register A value).
REQ-007 b_in  input  32  multiplier / divisor (register B value).
REQ-008 busy  output  1  high while the block is iterating (MULT or DIV state).
REQ-009 done  output  1  one-cycle pulse; hi_out/lo_out are valid this cycle, and the control unit drives HiWrite/LoWrite from it.
REQ-010 div_zero  output  1  valid with done; high when the accepted divide had b_in = 0.
REQ-011 hi_out  output  32  product[63:32] or remainder.
REQ-012 lo_out  output  32  product[31:0] or quotient.

Function
REQ-013 The block SHALL implement states IDLE, MULT, DIV and DONE.
- IDLE, start=1, op=0 -> MULT.
- IDLE, start=1, op=1, b_in!=0 -> DIV.
- IDLE, start=1, op=1, b_in=0 -> DONE.
- MULT or DIV, iteration counter reaches 31 -> DONE.
- DONE -> IDLE unconditionally.
REQ-014 a_in, b_in and op SHALL be captured on the edge that samples start; later input changes SHALL have no effect on the operation in progress.
REQ-015 Cycle numbering: cycle 0 is the clock cycle in which start is sampled high in IDLE; cycle N is N rising edges later.
REQ-016 Multiply SHALL use radix-2 Booth recoding over exactly 32 iterations and SHALL produce the full signed 64-bit product; done SHALL be high in cycle 33.
REQ-017 Divide SHALL be a 32-iteration restoring divide on magnitudes, followed by sign correction.
- Quotient truncates toward zero; the remainder takes the sign of the dividend.
- done SHALL be high in cycle 33.
REQ-018 Divide by zero SHALL assert done and div_zero in cycle 1, and hi_out/lo_out SHALL keep their previous values.
REQ-019 0x80000000 / 0xFFFFFFFF SHALL give quotient 0x80000000 (wrap) and remainder 0, with div_zero=0.
REQ-020 start in MULT, DIV or DONE SHALL be ignored; no request is queued.
REQ-021 busy SHALL be high exactly in MULT and DIV; done SHALL be high exactly in DONE; div_zero SHALL be low outside DONE.
REQ-022 hi_out/lo_out SHALL update only when entering DONE from MULT or DIV, and SHALL otherwise hold until the next successful result.

Reset
REQ-023 While reset is high at a clock edge, the next state SHALL be IDLE, the iteration counter 0, busy/done/div_zero 0 and hi_out/lo_out 0x00000000.
REQ-024 Reset asserted mid-operation SHALL abort it with no done pulse; reset has priority over start on the same edge.

Structure
REQ-025 The state enumeration, the op encoding (OP_MULT=0, OP_DIV=1) and the constant ITERATIONS=32 SHALL live in the shared package mult_div_pkg.
REQ-026 The block SHALL be a single module with no sub-module; the Booth step and divide step are inline combinational logic.

Verification
REQ-027 mult 7 x 0xFFFFFFFD (-3) -> done in cycle 33, hi=0xFFFFFFFF, lo=0xFFFFFFEB, busy high in cycles 1-32.
REQ-028 mult 0x7FFFFFFF x 0x7FFFFFFF -> hi=0x3FFFFFFF, lo=0x00000001.
REQ-029 div 0xFFFFFFF9 (-7) / 2 -> done in cycle 33, lo=0xFFFFFFFD, hi=0xFFFFFFFF, div_zero=0.
REQ-030 div 5 / 0 after a prior result hi=0x11, lo=0x22 -> done and div_zero in cycle 1; hi=0x11, lo=0x22 unchanged.
REQ-031 div 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0x00000000.
REQ-032 Start a mult; pulse start again in cycle 5; assert reset in cycle 10 -> second start ignored, no done pulse, all outputs 0 and IDLE next cycle; a fresh start then completes normally.
